// File: rtl/big_fv_bank_req_gen_pkg.sv
// Shared types for the Big FV output-bank request generator.
// Holds the bank-controller request/response packets, the sizing constants
// those packets are built from, and the request FSM state encoding.
package big_fv_bank_req_gen_pkg;

  // System sizing (mirrors the bank controller's shared definitions)
  localparam int MAX_FV_NUM      = 16;
  localparam int NUM_FV_LINE     = 4;
  localparam int MAX_NODE_ID     = 16;
  localparam int NUM_EDGE_PE     = 4;
  localparam int MAX_UPDATE_ITER = 4;
  localparam int FV_BANDWIDTH    = 32;

  localparam int NODE_ID_W = $clog2(MAX_NODE_ID);
  localparam int PE_TAG_W  = $clog2(NUM_EDGE_PE);
  localparam int ITER_W    = $clog2(MAX_UPDATE_ITER);

  // Request into the output SRAM bank controller
  typedef struct packed {
    logic                    valid;
    logic                    rd_wr;    // 1 = write, 0 = read
    logic [NODE_ID_W-1:0]    Node_id;
    logic [PE_TAG_W-1:0]     PE_tag;
    logic                    wr_eos;   // last beat of a write burst
    logic [FV_BANDWIDTH-1:0] data;
  } Req2Output_SRAM_Bank;

  // Read stream from the bank controller towards the Edge PEs
  typedef struct packed {
    logic                    valid;
    logic                    sos;
    logic                    eos;
    logic [PE_TAG_W-1:0]     PE_tag;
    logic [FV_BANDWIDTH-1:0] data;
  } FV_bank_CNTL2Edge_PE;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WB_BURST = 2'd1,
    ST_RD_WAIT  = 2'd2
  } req_state_e;

endpackage

// File: rtl/big_fv_bank_req_gen_fv_wb_line_buf.sv
// Single write-back line buffer: fills LINES lines, latches the node id on
// line 0, then drains one line per drain beat. Fill latency 1 cycle; buf_full
// is registered. Backpressure: wb_ready_o low from full until the last drain.
// Ports: wb_* fill side; drain_i/line_o/last_beat_o drain side; buf_full_o.
module fv_wb_line_buf
  import big_fv_bank_req_gen_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int NODE_W = NODE_ID_W,
  parameter int DATA_W = FV_BANDWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_valid_i,
  input  logic [NODE_W-1:0] wb_node_id_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_ready_o,
  input  logic              drain_i,
  output logic              buf_full_o,
  output logic [NODE_W-1:0] node_id_o,
  output logic [DATA_W-1:0] line_o,
  output logic              last_beat_o
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  logic [DATA_W-1:0] mem_q [LINES];
  logic [IDX_W-1:0]  wr_idx_q, rd_idx_q;
  logic              full_q;
  logic [NODE_W-1:0] node_q;
  logic              accept;

  assign accept      = wb_valid_i && !full_q;
  assign wb_ready_o  = !full_q;
  assign buf_full_o  = full_q;
  assign node_id_o   = node_q;
  assign line_o      = mem_q[rd_idx_q];
  assign last_beat_o = (rd_idx_q == IDX_W'(LINES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      full_q   <= 1'b0;
      node_q   <= '0;
    end else begin
      if (accept) begin
        if (wr_idx_q == '0) node_q <= wb_node_id_i;
        if (wr_idx_q == IDX_W'(LINES - 1)) begin
          wr_idx_q <= '0;
          full_q   <= 1'b1;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end
      // Drain only happens while full, so it never races a fill.
      if (drain_i) begin
        if (last_beat_o) begin
          rd_idx_q <= '0;
          full_q   <= 1'b0;
        end else begin
          rd_idx_q <= rd_idx_q + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_idx_q] <= wb_data_i;
  end

endmodule

// File: rtl/big_fv_bank_req_gen.sv
// Request initiator for the Big FV output bank: gap-free write-back bursts
// and Edge PE reads, alternating when both pend. req_pkt is combinational
// (0-cycle); rsp_out/rd_done lag rsp_in by 1. Issues only when available and
// Cur_Update_Iter[0]==0; wb_ready low while the single line buffer is full.
// Ports: wb_* fill, rd_* read requests, req_pkt out, rsp_in/rsp_out stream.
module big_fv_bank_req_gen
  import big_fv_bank_req_gen_pkg::*;
#(
  parameter int LINES_PER_NODE = MAX_FV_NUM / NUM_FV_LINE,
  parameter int NODE_W         = $clog2(MAX_NODE_ID),
  parameter int TAG_W          = $clog2(NUM_EDGE_PE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ITER_W-1:0]       Cur_Update_Iter,
  input  logic                    available,
  input  logic                    wb_valid,
  input  logic [NODE_W-1:0]       wb_node_id,
  input  logic [FV_BANDWIDTH-1:0] wb_data,
  output logic                    wb_ready,
  input  logic                    rd_valid,
  input  logic [NODE_W-1:0]       rd_node_id,
  input  logic [TAG_W-1:0]        rd_PE_tag,
  output logic                    rd_ready,
  output Req2Output_SRAM_Bank     req_pkt,
  input  FV_bank_CNTL2Edge_PE     rsp_in,
  output FV_bank_CNTL2Edge_PE     rsp_out,
  output logic                    rd_done,
  output logic                    protocol_err
);

  req_state_e          state_q, state_d;
  logic                buf_full, last_beat, wb_beat;
  logic [NODE_W-1:0]   buf_node_id;
  logic [FV_BANDWIDTH-1:0] buf_line;
  logic                last_was_wr_q, last_was_wr_d;
  logic [TAG_W-1:0]    tag_q;
  FV_bank_CNTL2Edge_PE rsp_out_q;
  logic                rd_done_q, err_q;
  logic                issue_ok, pick_wr, pick_rd, rsp_last;
  logic                unused_iter;

  assign unused_iter = ^Cur_Update_Iter[ITER_W-1:1];

  fv_wb_line_buf #(
    .LINES  (LINES_PER_NODE),
    .NODE_W (NODE_W),
    .DATA_W (FV_BANDWIDTH)
  ) u_line_buf (
    .clk_i        (clk),
    .rst_ni       (reset),
    .wb_valid_i   (wb_valid),
    .wb_node_id_i (wb_node_id),
    .wb_data_i    (wb_data),
    .wb_ready_o   (wb_ready),
    .drain_i      (wb_beat),
    .buf_full_o   (buf_full),
    .node_id_o    (buf_node_id),
    .line_o       (buf_line),
    .last_beat_o  (last_beat)
  );

  // Reset gates issue so req_pkt/rd_ready are zero the instant reset asserts.
  assign issue_ok = reset && available && !Cur_Update_Iter[0];
  // Write wins unless a read is also pending and the previous grant was a write.
  assign pick_wr  = (state_q == ST_IDLE) && issue_ok && buf_full &&
                    (!rd_valid || !last_was_wr_q);
  assign pick_rd  = (state_q == ST_IDLE) && issue_ok && rd_valid && !pick_wr;
  assign rsp_last = rsp_in.valid && rsp_in.eos;

  assign last_was_wr_d = pick_wr ? 1'b1 : (pick_rd ? 1'b0 : last_was_wr_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A one-line burst finishes in its issue cycle.
        if (pick_wr && !last_beat) state_d = ST_WB_BURST;
        else if (pick_rd)          state_d = ST_RD_WAIT;
      end
      ST_WB_BURST: if (last_beat) state_d = ST_IDLE;
      ST_RD_WAIT:  if (rsp_last)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_pkt  = '0;
    rd_ready = 1'b0;
    wb_beat  = 1'b0;
    if (pick_wr || state_q == ST_WB_BURST) begin
      req_pkt.valid   = 1'b1;
      req_pkt.rd_wr   = 1'b1;
      req_pkt.Node_id = NODE_ID_W'(buf_node_id);
      req_pkt.data    = buf_line;
      req_pkt.wr_eos  = last_beat;
      wb_beat         = 1'b1;
    end else if (pick_rd) begin
      req_pkt.valid   = 1'b1;
      req_pkt.Node_id = NODE_ID_W'(rd_node_id);
      req_pkt.PE_tag  = PE_TAG_W'(rd_PE_tag);
      rd_ready        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_was_wr_q <= 1'b0;
      tag_q         <= '0;
      rsp_out_q     <= '0;
      rd_done_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      last_was_wr_q <= last_was_wr_d;
      if (pick_rd) tag_q <= rd_PE_tag;
      rsp_out_q <= rsp_in;
      rd_done_q <= (state_q == ST_RD_WAIT) && rsp_last;
      if (rsp_in.valid && ((state_q != ST_RD_WAIT) ||
                           (rsp_in.PE_tag != PE_TAG_W'(tag_q))))
        err_q <= 1'b1;
    end
  end

  assign rsp_out      = rsp_out_q;
  assign rd_done      = rd_done_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_big_fv_bank_req_gen.sv
module tb_big_fv_bank_req_gen;
  import big_fv_bank_req_gen_pkg::*;

  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [ITER_W-1:0]       iter;
  logic                    available, wb_valid, wb_ready, rd_valid, rd_ready;
  logic [NODE_ID_W-1:0]    wb_node_id, rd_node_id;
  logic [FV_BANDWIDTH-1:0] wb_data;
  logic [PE_TAG_W-1:0]     rd_PE_tag;
  Req2Output_SRAM_Bank     req_pkt;
  FV_bank_CNTL2Edge_PE     rsp_in, rsp_out;
  logic                    rd_done, protocol_err;

  big_fv_bank_req_gen #(.LINES_PER_NODE(L)) dut (
    .clk(clk), .reset(reset), .Cur_Update_Iter(iter), .available(available),
    .wb_valid(wb_valid), .wb_node_id(wb_node_id), .wb_data(wb_data),
    .wb_ready(wb_ready), .rd_valid(rd_valid), .rd_node_id(rd_node_id),
    .rd_PE_tag(rd_PE_tag), .rd_ready(rd_ready), .req_pkt(req_pkt),
    .rsp_in(rsp_in), .rsp_out(rsp_out), .rd_done(rd_done),
    .protocol_err(protocol_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  // Behavioural reference: buffered lines, remaining burst lines, read-busy.
  logic [FV_BANDWIDTH-1:0] m_lines[$];
  logic [FV_BANDWIDTH-1:0] m_burst[$];
  bit                      m_full, m_rd_busy, m_last_wr, m_err, m_prev_done;
  logic [NODE_ID_W-1:0]    m_node;
  logic [PE_TAG_W-1:0]     m_tag;
  FV_bank_CNTL2Edge_PE     m_prev_rsp;
  int                      exp_pick;   // 0 none, 1 write, 2 read
  // Responder (plays the bank controller) and coverage
  int                      rs_cnt;
  bit                      rs_first, inj, did_rst;
  int                      n_wr, n_rd, n_both;

  task automatic model_reset();
    m_lines.delete(); m_burst.delete();
    m_full = 0; m_rd_busy = 0; m_last_wr = 0; m_err = 0; m_prev_done = 0;
    m_node = '0; m_tag = '0; m_prev_rsp = '0; exp_pick = 0; rs_cnt = 0; rs_first = 0;
  endtask

  task automatic drive_inputs();
    wb_valid   = ($urandom_range(0, 3) != 0);
    wb_data    = $urandom;
    wb_node_id = NODE_ID_W'($urandom);
    rd_valid   = ($urandom_range(0, 4) < 2);
    rd_node_id = NODE_ID_W'($urandom);
    rd_PE_tag  = PE_TAG_W'($urandom);
    available  = ($urandom_range(0, 5) != 0);
    iter       = ITER_W'($urandom);
    iter[0]    = ($urandom_range(0, 6) == 0);
    rsp_in     = '0;
    if (m_rd_busy && rs_cnt > 0 && $urandom_range(0, 2) != 0) begin
      rsp_in.valid  = 1'b1;
      rsp_in.sos    = rs_first;
      rsp_in.eos    = (rs_cnt == 1);
      rsp_in.PE_tag = m_tag;
      rsp_in.data   = $urandom;
      if (inj && $urandom_range(0, 3) == 0) rsp_in.PE_tag = m_tag + 1'b1;
      rs_first = 0;
      rs_cnt--;
    end else if (inj && !m_rd_busy && $urandom_range(0, 3) == 0) begin
      rsp_in.valid  = 1'b1;
      rsp_in.eos    = 1'($urandom);
      rsp_in.PE_tag = PE_TAG_W'($urandom);
      rsp_in.data   = $urandom;
    end
  endtask

  task automatic compute_and_check();
    Req2Output_SRAM_Bank exp_req;
    bit ok;
    ok       = available && !iter[0];
    exp_pick = 0;
    exp_req  = '0;
    if (m_burst.size() == 0 && !m_rd_busy && ok) begin
      if (m_full && (!rd_valid || !m_last_wr)) exp_pick = 1;
      else if (rd_valid)                       exp_pick = 2;
    end
    if (m_burst.size() > 0 || exp_pick == 1) begin
      exp_req.valid   = 1'b1;
      exp_req.rd_wr   = 1'b1;
      exp_req.Node_id = m_node;
      exp_req.data    = (m_burst.size() > 0) ? m_burst[0] : m_lines[0];
      exp_req.wr_eos  = (m_burst.size() > 0) ? (m_burst.size() == 1) : (L == 1);
    end else if (exp_pick == 2) begin
      exp_req.valid   = 1'b1;
      exp_req.Node_id = rd_node_id;
      exp_req.PE_tag  = rd_PE_tag;
    end
    chk("wb_ready",     64'(wb_ready),     64'(!m_full));
    chk("req_pkt",      64'(req_pkt),      64'(exp_req));
    chk("rd_ready",     64'(rd_ready),     64'(exp_pick == 2));
    chk("rsp_out",      64'(rsp_out),      64'(m_prev_rsp));
    chk("rd_done",      64'(rd_done),      64'(m_prev_done));
    chk("protocol_err", 64'(protocol_err), 64'(m_err));
  endtask

  task automatic update_model();
    bit acc, was_busy;
    acc      = wb_valid && !m_full;
    was_busy = m_rd_busy;
    if (m_full && rd_valid && m_burst.size() == 0 && !m_rd_busy) n_both++;
    if (rsp_in.valid && (!was_busy || rsp_in.PE_tag != m_tag)) m_err = 1;
    m_prev_done = was_busy && rsp_in.valid && rsp_in.eos;
    m_prev_rsp  = rsp_in;
    if (m_prev_done) m_rd_busy = 0;
    if (m_burst.size() > 0) begin
      void'(m_burst.pop_front());
      if (m_burst.size() == 0) begin m_lines.delete(); m_full = 0; end
    end else if (exp_pick == 1) begin
      n_wr++;
      m_last_wr = 1;
      for (int k = 1; k < L; k++) m_burst.push_back(m_lines[k]);
      if (L == 1) begin m_lines.delete(); m_full = 0; end
    end else if (exp_pick == 2) begin
      n_rd++;
      m_last_wr = 0;
      m_tag     = rd_PE_tag;
      m_rd_busy = 1;
      rs_cnt    = $urandom_range(1, 4);
      rs_first  = 1;
    end
    if (acc) begin
      if (m_lines.size() == 0) m_node = wb_node_id;
      m_lines.push_back(wb_data);
      if (m_lines.size() == L) m_full = 1;
    end
  endtask

  initial begin
    reset = 1'b0; iter = '0; available = 0; wb_valid = 0; wb_node_id = '0;
    wb_data = '0; rd_valid = 0; rd_node_id = '0; rd_PE_tag = '0; rsp_in = '0;
    inj = 0; did_rst = 0; n_wr = 0; n_rd = 0; n_both = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_wb_ready", 64'(wb_ready), 64'(1));
    chk("rst_req_pkt",  64'(req_pkt),  64'(0));
    chk("rst_rsp_out",  64'(rsp_out),  64'(0));
    chk("rst_rd_done",  64'(rd_done),  64'(0));
    chk("rst_err",      64'(protocol_err), 64'(0));
    reset = 1'b1;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk);
      inj = (cyc >= 2100);
      drive_inputs();
      // Reset in the middle of a burst, on the beat carrying line 2.
      if (!did_rst && cyc >= 1000 && m_burst.size() == L - 2) begin
        did_rst = 1;
        reset   = 1'b0;
        #1;
        chk("midrst_req_pkt",  64'(req_pkt),  64'(0));
        chk("midrst_wb_ready", 64'(wb_ready), 64'(1));
        chk("midrst_rd_ready", 64'(rd_ready), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_inputs();
      end
      #1 compute_and_check();
      @(posedge clk);
      update_model();
    end

    @(negedge clk);
    chk("mid_burst_reset_seen", 64'(did_rst),     64'(1));
    chk("writes_seen",          64'(n_wr > 10),   64'(1));
    chk("reads_seen",           64'(n_rd > 10),   64'(1));
    chk("contention_seen",      64'(n_both > 0),  64'(1));
    chk("err_sticky_end",       64'(protocol_err), 64'(1));
    reset = 1'b0;
    #1;
    chk("final_rst_err",      64'(protocol_err), 64'(0));
    chk("final_rst_wb_ready", 64'(wb_ready),     64'(1));
    chk("final_rst_req_pkt",  64'(req_pkt),      64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
